blit_writer: RTL and testbench

BLIT_WRITER -- requirements
Module: blit_writer

---
 rtl/blit_writer_pkg.sv | 19 +
 rtl/blit_addr_gen.sv | 107 ++++++++++
 rtl/blit_writer.sv | 129 ++++++++++++
 tb/tb_blit_writer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/blit_writer_pkg.sv
// Shared FSM encoding and geometry constants for the sprite blitter.
// Clipping is controlled by the BLIT_CLIP_EN macro in blit_addr_gen.
package blit_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_READ       = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_DONE       = 3'd4
    } blit_state_e;

    localparam int BW_SCREEN_W = 160;
    localparam int BW_SCREEN_H = 120;
    localparam int BW_SP_W     = 16;
    localparam int BW_SP_H     = 16;
    localparam int BW_ADDR_W   = 17;

endpackage

// File: rtl/blit_addr_gen.sv
// Row/column scan counters plus sprite ROM and background GRAM address arithmetic.
// BLIT_CLIP_EN widens the coordinate sums by one bit and flags off-screen pixels.
module blit_addr_gen
    import blit_writer_pkg::*;
#(
    parameter int SP_W     = BW_SP_W,
    parameter int SP_H     = BW_SP_H,
    parameter int SCREEN_W = BW_SCREEN_W,
    parameter int SCREEN_H = BW_SCREEN_H,
    parameter int ADDR_W   = BW_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [7:0]        src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [7:0]        dst_x,
    input  logic [6:0]        dst_y,
    output logic [7:0]        rom_addr,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              pix_vis,
    output logic              last_pix
);

    localparam int CW = (SP_W > 1) ? $clog2(SP_W) : 1;
    localparam int RW = (SP_H > 1) ? $clog2(SP_H) : 1;
`ifdef BLIT_CLIP_EN
    localparam int XW = $clog2(SCREEN_W) + 1;
    localparam int YW = $clog2(SCREEN_H) + 1;
`else
    localparam int XW = $clog2(SCREEN_W);
    localparam int YW = $clog2(SCREEN_H);
`endif

    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [7:0]        rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] dst_base_q, dst_base_d;
    logic [7:0]        dst_x_q, dst_x_d;
    logic [6:0]        dst_y_q, dst_y_d;
    logic [XW-1:0]     col_sum_s;
    logic [YW-1:0]     row_sum_s;

    // Counter and base-register next state; rom_addr just increments since the scan is row-major
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        rom_addr_d = rom_addr_q;
        dst_base_d = dst_base_q;
        dst_x_d    = dst_x_q;
        dst_y_d    = dst_y_q;
        if (load) begin
            col_d      = '0;
            row_d      = '0;
            rom_addr_d = src_base;
            dst_base_d = dst_base;
            dst_x_d    = dst_x;
            dst_y_d    = dst_y;
        end else if (advance) begin
            rom_addr_d = rom_addr_q + 8'd1;
            if (col_q == CW'(SP_W - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Counter and base registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            rom_addr_q <= 8'd0;
            dst_base_q <= '0;
            dst_x_q    <= 8'd0;
            dst_y_q    <= 7'd0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            rom_addr_q <= rom_addr_d;
            dst_base_q <= dst_base_d;
            dst_x_q    <= dst_x_d;
            dst_y_q    <= dst_y_d;
        end
    end

    // Destination address of the pixel currently being read
    always_comb begin
        col_sum_s = XW'(dst_x_q) + XW'(col_q);
        row_sum_s = YW'(dst_y_q) + YW'(row_q);
`ifdef BLIT_CLIP_EN
        pix_vis   = (col_sum_s < XW'(SCREEN_W)) && (row_sum_s < YW'(SCREEN_H));
`else
        pix_vis   = 1'b1;
`endif
        pix_addr  = dst_base_q + ADDR_W'(col_sum_s) + ADDR_W'(SCREEN_W) * ADDR_W'(row_sum_s);
        last_pix  = (row_q == RW'(SP_H - 1)) && (col_q == CW'(SP_W - 1));
    end

    assign rom_addr = rom_addr_q;

endmodule

// File: rtl/blit_writer.sv
// Sprite-to-background copy engine: control FSM and one-stage write pipeline.
// Optional clipping of off-screen pixels via BLIT_CLIP_EN (see blit_addr_gen).
module blit_writer
    import blit_writer_pkg::*;
#(
    parameter int SP_W     = BW_SP_W,
    parameter int SP_H     = BW_SP_H,
    parameter int SCREEN_W = BW_SCREEN_W,
    parameter int SCREEN_H = BW_SCREEN_H,
    parameter int ADDR_W   = BW_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [7:0]        dst_x,
    input  logic [6:0]        dst_y,
    input  logic              transparent,
    input  logic              sync_frame,
    input  logic              screenEnd,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rom_addr,
    input  logic              rom_data,
    output logic [ADDR_W-1:0] gram_addr,
    output logic              gram_wEn,
    output logic              gram_dataIn
);

    blit_state_e       state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              slot_q, slot_d;
    logic              vis_q, vis_d;
    logic              transp_q, transp_d;
    logic              dat_q, dat_d;
    logic [ADDR_W-1:0] gram_addr_q, gram_addr_d;
    logic              accept_s;
    logic              gram_wEn_s;
    logic              gram_dataIn_s;
    logic [ADDR_W-1:0] pix_addr_s;
    logic              pix_vis_s;
    logic              last_pix_s;

    assign accept_s = (state_q == ST_IDLE) && start && !busy_q;

    blit_addr_gen #(
        .SP_W     (SP_W),
        .SP_H     (SP_H),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (reset),
        .load     (accept_s),
        .advance  (state_q == ST_READ),
        .src_base (src_base),
        .dst_base (dst_base),
        .dst_x    (dst_x),
        .dst_y    (dst_y),
        .rom_addr (rom_addr),
        .pix_addr (pix_addr_s),
        .pix_vis  (pix_vis_s),
        .last_pix (last_pix_s)
    );

    // State and pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slot_q      <= 1'b0;
            vis_q       <= 1'b0;
            transp_q    <= 1'b0;
            dat_q       <= 1'b0;
            gram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            slot_q      <= slot_d;
            vis_q       <= vis_d;
            transp_q    <= transp_d;
            dat_q       <= dat_d;
            gram_addr_q <= gram_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       state_d = accept_s ? (sync_frame ? ST_WAIT_FRAME : ST_READ) : ST_IDLE;
            ST_WAIT_FRAME: state_d = screenEnd ? ST_READ : ST_WAIT_FRAME;
            ST_READ:       state_d = last_pix_s ? ST_DRAIN : ST_READ;
            ST_DRAIN:      state_d = ST_DONE;
            ST_DONE:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Outputs; ROM data arrives with the write slot, so wEn/data pass it straight through
    always_comb begin
        busy_d      = (state_d != ST_IDLE) || (state_q == ST_DONE);
        done_d      = (state_q == ST_DONE);
        slot_d      = (state_q == ST_READ);
        transp_d    = accept_s ? transparent : transp_q;
        if (state_q == ST_READ) begin
            gram_addr_d = pix_addr_s;
            vis_d       = pix_vis_s;
        end else begin
            gram_addr_d = gram_addr_q;
            vis_d       = vis_q;
        end
        gram_dataIn_s = slot_q ? rom_data : dat_q;
        gram_wEn_s    = slot_q && vis_q && (!transp_q || rom_data);
        dat_d         = gram_dataIn_s;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign gram_addr   = gram_addr_q;
    assign gram_wEn    = gram_wEn_s;
    assign gram_dataIn = gram_dataIn_s;

endmodule

// File: tb/tb_blit_writer.sv
// Directed scoreboard bench for blit_writer; expected GRAM writes are queued when a copy
// is started and checked as the DUT writes them.
module tb_blit_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_base = 8'd0;
    logic [16:0] dst_base = 17'd0;
    logic [7:0]  dst_x = 8'd0;
    logic [6:0]  dst_y = 7'd0;
    logic        transparent = 1'b0;
    logic        sync_frame = 1'b0;
    logic        screenEnd = 1'b0;
    logic        busy, done, gram_wEn, gram_dataIn;
    logic [7:0]  rom_addr;
    logic        rom_data = 1'b0;
    logic [16:0] gram_addr;

    logic        rom [256];
    logic [17:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_wr = -1;
    logic        busy_at_done = 1'b0;

    blit_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .dst_x       (dst_x),
        .dst_y       (dst_y),
        .transparent (transparent),
        .sync_frame  (sync_frame),
        .screenEnd   (screenEnd),
        .busy        (busy),
        .done        (done),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .gram_addr   (gram_addr),
        .gram_wEn    (gram_wEn),
        .gram_dataIn (gram_dataIn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Write monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (gram_wEn === 1'b1) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_write: observed addr %0d data %0d expected no write", gram_addr, gram_dataIn);
            end
            if (exp_q.size() != 0) begin
                logic [17:0] e;
                e = exp_q.pop_front();
                vectors++;
                assert ({gram_addr, gram_dataIn} === e) else begin
                    miscompares++;
                    $error("FAIL write: observed addr %0d data %0d expected addr %0d data %0d",
                           gram_addr, gram_dataIn, e[17:1], e[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the expected writes, then pulse start; acc returns the accept cycle number
    task automatic start_copy(input logic [7:0] sb, input logic [16:0] db, input logic [7:0] x,
                              input logic [6:0] y, input logic tr, input logic sy, output int acc);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int cs, rs;
                logic vis;
                logic d;
                logic [7:0] idx;
                logic [16:0] a;
`ifdef BLIT_CLIP_EN
                cs  = int'(x) + c;
                rs  = int'(y) + r;
                vis = (cs < 160) && (rs < 120);
`else
                cs  = (int'(x) + c) % 256;
                rs  = (int'(y) + r) % 128;
                vis = 1'b1;
`endif
                idx = sb + 8'(r * 16 + c);
                d   = rom[idx];
                a   = db + 17'(cs) + 17'(160 * rs);
                if (vis && !(tr && !d)) exp_q.push_back({a, d});
            end
        end
        src_base    = sb;
        dst_base    = db;
        dst_x       = x;
        dst_y       = y;
        transparent = tr;
        sync_frame  = sy;
        start       = 1'b1;
        acc         = cyc;
        tick(1);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_within_budget", (done_cnt != d0), 1'b1);
        tick(3);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acc, w0, d0, se;

        // Reset state
        tick(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wEn", gram_wEn, 1'b0);
        chk("rst_gram_addr", gram_addr, 17'd0);
        chk("rst_dataIn", gram_dataIn, 1'b0);
        chk("rst_rom_addr", rom_addr, 8'd0);
        reset = 1'b1;
        tick(2);

        // Full copy, ROM all ones
        for (int i = 0; i < 256; i++) rom[i] = 1'b1;
        w0 = wr_cnt; d0 = done_cnt; first_wr = -1;
        chk("idle_busy", busy, 1'b0);
        start_copy(8'd0, 17'd0, 8'd0, 7'd0, 1'b0, 1'b0, acc);
        chk("busy_after_accept", busy, 1'b1);
        wait_done(d0, 400);
        chk("s1_writes", wr_cnt - w0, 256);
        chk("s1_first_write_lat", first_wr - acc, 2);
        chk("s1_done_lat", done_cyc - acc, 259);
        chk("s1_done_count", done_cnt - d0, 1);
        chk("s1_busy_at_done", busy_at_done, 1'b1);
        chk("s1_busy_after", busy, 1'b0);

        // Transparent copy of a checkerboard
        for (int i = 0; i < 256; i++) rom[i] = 1'((i + (i >> 4)) & 1);
        w0 = wr_cnt; d0 = done_cnt;
        start_copy(8'd0, 17'd0, 8'd0, 7'd0, 1'b1, 1'b0, acc);
        wait_done(d0, 400);
        chk("s2_writes", wr_cnt - w0, 128);

        // Frame-synchronised start; the screenEnd in the accept cycle must not count
        for (int i = 0; i < 256; i++) rom[i] = 1'($urandom_range(1, 0));
        w0 = wr_cnt; d0 = done_cnt; first_wr = -1;
        screenEnd = 1'b1;
        start_copy(8'd33, 17'd77, 8'd20, 7'd9, 1'b0, 1'b1, acc);
        screenEnd = 1'b0;
        tick(acc + 50 - cyc);
        se = cyc;
        screenEnd = 1'b1;
        tick(1);
        screenEnd = 1'b0;
        wait_done(d0, 400);
        chk("s3_no_early_write", first_wr - se, 2);
        chk("s3_done_lat", done_cyc - se, 259);
        chk("s3_writes", wr_cnt - w0, 256);

        // Edge-of-screen placement
        w0 = wr_cnt; d0 = done_cnt;
        start_copy(8'd200, 17'd5, 8'd150, 7'd110, 1'b0, 1'b0, acc);
        wait_done(d0, 400);
`ifdef BLIT_CLIP_EN
        chk("s4_clip_writes", wr_cnt - w0, 100);
`else
        chk("s4_wrap_writes", wr_cnt - w0, 256);
`endif

        // Reset mid-copy, then a full copy
        for (int i = 0; i < 256; i++) rom[i] = 1'b1;
        w0 = wr_cnt;
        start_copy(8'd0, 17'd1000, 8'd3, 7'd4, 1'b0, 1'b0, acc);
        for (int n = 0; n < 200 && (wr_cnt - w0) < 40; n++) tick(1);
        chk("s5_reached_40", (wr_cnt - w0) >= 40, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("s5_rst_wEn", gram_wEn, 1'b0);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_rom_addr", rom_addr, 8'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b1;
        w0 = wr_cnt;
        tick(2);
        chk("s5_no_write_after_rst", wr_cnt - w0, 0);
        d0 = done_cnt;
        start_copy(8'd0, 17'd1000, 8'd3, 7'd4, 1'b0, 1'b0, acc);
        wait_done(d0, 400);
        chk("s5_full_writes", wr_cnt - w0, 256);

        // Second start mid-copy is ignored
        w0 = wr_cnt; d0 = done_cnt;
        start_copy(8'd16, 17'd500, 8'd40, 7'd50, 1'b0, 1'b0, acc);
        tick(100);
        src_base = 8'd99; dst_base = 17'd7; dst_x = 8'd1; dst_y = 7'd1; transparent = 1'b1;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(d0, 400);
        chk("s6_writes", wr_cnt - w0, 256);
        chk("s6_done_count", done_cnt - d0, 1);
        chk("s6_done_lat", done_cyc - acc, 259);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
